// File: rtl/frac_clk_pkg.sv
// Shared types and helpers for the fractional-N clock generator:
// config FSM states, half-rate increment ceiling and the increment clamp.
package frac_clk_pkg;

  localparam int ACC_W_DEF = 16;
  localparam logic [31:0] HALF_INC = 32'd1 << (ACC_W_DEF - 1);

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_e;

  function automatic logic [31:0] half_inc(input int acc_w);
    return 32'd1 << (acc_w - 1);
  endfunction

  // Increments above half scale would alias below clkin/2, so cap them there.
  function automatic logic [31:0] clamp_inc(input logic [31:0] inc, input int acc_w);
    logic [31:0] half;
    half = half_inc(acc_w);
    return (inc > half) ? half : inc;
  endfunction

endpackage

// File: rtl/frac_clk_chan.sv
// One fractional-N channel: phase accumulator, registered clkout/tick and
// a saturating lock counter. Retunes only when the top asserts apply.
module frac_clk_chan #(
  parameter int                 ACC_W       = 16,
  parameter logic [ACC_W-1:0]   DEFAULT_INC = ACC_W'(32'h4000),
  parameter int                 LOCK_TICKS  = 4
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             capture,
  input  logic             apply,
  input  logic [ACC_W-1:0] new_inc,
  output logic             clkout,
  output logic             tick,
  output logic             lock,
  output logic             running,
  output logic             tick_next
);

  localparam int CNT_W = $clog2(LOCK_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TICKS);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q;
  logic             clkout_q;
  logic             tick_q;
  logic             lock_q;

  assign running   = |inc_q;
  assign sum       = acc_q + inc_q;
  assign tick_next = running & sum[ACC_W-1] & ~acc_q[ACC_W-1];

  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign lock   = lock_q;

  always_ff @(posedge clkin) begin
    if (reset) begin
      acc_q    <= '0;
      inc_q    <= DEFAULT_INC;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
      lock_q   <= 1'b0;
    end else begin
      // A stopped channel parks at phase 0 so a restart begins cleanly.
      if (!running) begin
        acc_q    <= '0;
        clkout_q <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        acc_q    <= sum;
        clkout_q <= sum[ACC_W-1];
        tick_q   <= tick_next;
      end

      if (apply) begin
        inc_q <= new_inc;
      end

      // The tick on the apply edge still belongs to the old ratio.
      if (capture || !running) begin
        cnt_q <= '0;
      end else if (tick_next && !apply && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      lock_q <= running && !capture && (cnt_q == CNT_MAX);
    end
  end

endmodule

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional-N clock generator: config handshake with a single
// pending slot, apply-strobe decode and one frac_clk_chan per output.
module frac_clk_gen
  import frac_clk_pkg::*;
#(
  parameter int               NCHAN       = 2,
  parameter int               ACC_W       = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(32'h4000),
  parameter int               LOCK_TICKS  = 4,
  localparam int              CH_W        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic [NCHAN-1:0] clkout,
  output logic [NCHAN-1:0] tick,
  output logic [NCHAN-1:0] lock
);

  localparam logic [ACC_W-1:0] DEF_INC_CLAMPED = ACC_W'(clamp_inc(32'(DEFAULT_INC), ACC_W));
  localparam logic [CH_W:0]    NCHAN_L         = (CH_W + 1)'(NCHAN);

  cfg_state_e       state_q;
  cfg_state_e       state_d;
  logic [CH_W-1:0]  pend_chan_q;
  logic [ACC_W-1:0] pend_inc_q;
  logic             xfer;
  logic             chan_ok;
  logic             take;
  logic [NCHAN-1:0] capture;
  logic [NCHAN-1:0] apply;
  logic [NCHAN-1:0] running;
  logic [NCHAN-1:0] tick_next;

  assign cfg_ready = (state_q == CFG_IDLE);
  assign xfer      = cfg_valid & cfg_ready;
  assign chan_ok   = ({1'b0, cfg_chan} < NCHAN_L);
  assign take      = xfer & chan_ok;

  always_comb begin
    state_d = state_q;
    capture = '0;
    apply   = '0;
    case (state_q)
      CFG_IDLE: begin
        if (take) begin
          state_d = CFG_PENDING;
          for (int i = 0; i < NCHAN; i++) begin
            capture[i] = (cfg_chan == CH_W'(i));
          end
        end
      end
      CFG_PENDING: begin
        // Running targets wait for their next rising edge so the switch is
        // phase-continuous; stopped targets take the new ratio immediately.
        for (int i = 0; i < NCHAN; i++) begin
          apply[i] = (pend_chan_q == CH_W'(i)) && (running[i] ? tick_next[i] : 1'b1);
        end
        if (|apply) begin
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= CFG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clkin) begin
    if (take) begin
      pend_chan_q <= cfg_chan;
      pend_inc_q  <= ACC_W'(clamp_inc(32'(cfg_inc), ACC_W));
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    frac_clk_chan #(
      .ACC_W      (ACC_W),
      .DEFAULT_INC(DEF_INC_CLAMPED),
      .LOCK_TICKS (LOCK_TICKS)
    ) u_chan (
      .clkin    (clkin),
      .reset    (reset),
      .capture  (capture[i]),
      .apply    (apply[i]),
      .new_inc  (pend_inc_q),
      .clkout   (clkout[i]),
      .tick     (tick[i]),
      .lock     (lock[i]),
      .running  (running[i]),
      .tick_next(tick_next[i])
    );
  end

endmodule
